control_unit: RTL and testbench



---
 rtl/cu_pkg.sv | 54 +++++
 rtl/cu_alu.sv | 53 +++++
 rtl/control_unit.sv | 109 ++++++++++
 tb/tb_control_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and widths for the accumulator core: opcode and FSM state encodings.
// With CU_MUL_EN defined, opcode C is MUL and also updates the carry flag.
package cu_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  // OP_NOT is MUL when the CU_MUL_EN build option is enabled
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_STA = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_XOR = 4'h7,
    OP_LDI = 4'h8,
    OP_JMP = 4'h9,
    OP_JZ  = 4'hA,
    OP_JC  = 4'hB,
    OP_NOT = 4'hC,
    OP_SHL = 4'hD,
    OP_SHR = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_t;

  function automatic logic writes_acc(opcode_t op);
    case (op)
      OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LDI, OP_NOT, OP_SHL, OP_SHR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic updates_carry(opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_SHL, OP_SHR: return 1'b1;
`ifdef CU_MUL_EN
      OP_NOT:                         return 1'b1;
`endif
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_alu.sv
// Combinational ALU for the accumulator core; carry passes through for ops that leave it alone.
// CU_MUL_EN turns opcode C from NOT into an 8x8 multiply keeping the low byte.
module cu_alu
  import cu_pkg::*;
(
  input  opcode_t             opcode,
  input  logic [DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]   mdr,
  input  logic                c_in,
  output logic [DATA_W-1:0]   result,
  output logic                carry,
  output logic                zero
);

`ifdef CU_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, mdr};
`endif

  // SUB borrow falls out of the 9-bit subtraction as bit 8
  always_comb begin
    result = acc;
    carry  = c_in;
    case (opcode)
      OP_LDA, OP_LDI: result = mdr;
      OP_ADD:         {carry, result} = {1'b0, acc} + {1'b0, mdr};
      OP_SUB:         {carry, result} = {1'b0, acc} - {1'b0, mdr};
      OP_AND:         result = acc & mdr;
      OP_OR:          result = acc | mdr;
      OP_XOR:         result = acc ^ mdr;
`ifdef CU_MUL_EN
      OP_NOT: begin
        result = prod[DATA_W-1:0];
        carry  = |prod[2*DATA_W-1:DATA_W];
      end
`else
      OP_NOT:         result = ~acc;
`endif
      OP_SHL: begin
        carry  = acc[DATA_W-1];
        result = {acc[DATA_W-2:0], 1'b0};
      end
      OP_SHR: begin
        carry  = acc[0];
        result = {1'b0, acc[DATA_W-1:1]};
      end
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/control_unit.sv
// 8-bit accumulator processor: 3-clock FETCH/DECODE/EXECUTE FSM, program ROM, data RAM.
// Build option CU_MUL_EN (see cu_alu) replaces NOT with MUL.
module control_unit
  import cu_pkg::*;
#(
  parameter string ROM_FILE  = "program.mem",
  parameter int    ROM_DEPTH = 256,
  parameter int    RAM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [1:0]        flags_o,
  output logic              halted_o
);

  logic [INSTR_W-1:0] rom [ROM_DEPTH];
  logic [DATA_W-1:0]  ram [RAM_DEPTH];

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  mdr;
  logic [DATA_W-1:0]  acc;
  logic               c_flag;
  logic               z_flag;

  opcode_t            ir_op;
  logic [7:0]         operand;
  logic [DATA_W-1:0]  alu_b;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_carry;
  logic               alu_zero;
  logic               unused_ir_bits;

  // Memory contents at time 0; reset never touches them
  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = '0;
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = '0;
  end

  assign ir_op          = opcode_t'(ir[15:12]);
  assign operand        = ir[7:0];
  assign unused_ir_bits = ^ir[11:8];
  assign alu_b          = (ir_op == OP_LDI) ? operand : mdr;

  cu_alu u_alu (
    .opcode (ir_op),
    .acc    (acc),
    .mdr    (alu_b),
    .c_in   (c_flag),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Store lands in EXECUTE, so a following DECODE read already sees it
  always_ff @(posedge clk) begin
    if (state == EXECUTE && ir_op == OP_STA) ram[operand] <= acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      mdr    <= '0;
      acc    <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= rom[pc];
          pc    <= pc + 8'd1;
          state <= DECODE;
        end
        DECODE: begin
          mdr   <= ram[operand];
          state <= EXECUTE;
        end
        EXECUTE: begin
          state <= (ir_op == OP_HLT) ? HALT : FETCH;
          if (writes_acc(ir_op)) begin
            acc    <= alu_result;
            z_flag <= alu_zero;
          end
          if (updates_carry(ir_op)) c_flag <= alu_carry;
          // Jump conditions use the flags as they were entering EXECUTE
          case (ir_op)
            OP_JMP:  pc <= operand;
            OP_JZ:   if (z_flag) pc <= operand;
            OP_JC:   if (c_flag) pc <= operand;
            default: ;
          endcase
        end
        HALT: ;
        default: state <= FETCH;
      endcase
    end
  end

  assign pc_o     = pc;
  assign acc_o    = acc;
  assign flags_o  = {c_flag, z_flag};
  assign halted_o = (state == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed programs are poked into ROM, expected
// halt/probe snapshots are queued, and a monitor compares them when the DUT presents them.
module tb_control_unit;
  import cu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc;
  logic [7:0] acc;
  logic [1:0] flags;
  logic       halted;

  control_unit #(.ROM_FILE("")) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_o     (pc),
    .acc_o    (acc),
    .flags_o  (flags),
    .halted_o (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [7:0] acc;
    logic [1:0] flags;
    logic       halted;
  } exp_t;

  exp_t haltQ[$];
  exp_t probeQ[$];
  int   compared = 0;
  int   mismatched = 0;
  event probeEv;
  logic prevHalted = 1'b0;

  function automatic exp_t mkExp(string name, logic [7:0] p, logic [7:0] a,
                                 logic [1:0] f, logic h);
    exp_t e;
    e.name = name; e.pc = p; e.acc = a; e.flags = f; e.halted = h;
    return e;
  endfunction

  function automatic logic [15:0] ins(opcode_t op, logic [7:0] operand);
    return {op, 4'h0, operand};
  endfunction

  task automatic compareField(string name, string field, logic [7:0] act, logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, req);
    end
  endtask

  task automatic checkOutput(input bit fromProbe);
    exp_t e;
    if ((fromProbe && probeQ.size() == 0) || (!fromProbe && haltQ.size() == 0)) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unexpected_output: DUT presented pc=0x%0h acc=0x%0h with nothing queued",
               pc, acc);
      return;
    end
    e = fromProbe ? probeQ.pop_front() : haltQ.pop_front();
    compareField(e.name, "pc", pc, e.pc);
    compareField(e.name, "acc", acc, e.acc);
    compareField(e.name, "flags", {6'd0, flags}, {6'd0, e.flags});
    compareField(e.name, "halted", {7'd0, halted}, {7'd0, e.halted});
  endtask

  // Monitor: a HALT entry is the DUT's "result valid"; probes are explicit snapshots
  always @(negedge clk) begin
    if (halted && !prevHalted) checkOutput(1'b0);
    prevHalted <= halted;
  end

  initial forever begin
    @(probeEv);
    checkOutput(1'b1);
  end

  task automatic holdReset(string name);
    reset = 1'b0;
    #1;
    probeQ.push_back(mkExp({name, "_reset"}, 8'h00, 8'h00, 2'b00, 1'b0));
    ->probeEv;
    #1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) dut.rom[i] = 16'h0000;
  endtask

  task automatic applyStimulus(string name, logic [7:0] p, logic [7:0] a,
                               logic [1:0] f, int budget);
    bit done = 0;
    haltQ.push_back(mkExp(name, p, a, f, 1'b1));
    reset = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (halted) done = 1;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s.timeout: no halt within %0d clocks, expected halt", name, budget);
      void'(haltQ.pop_back());
    end else begin
      repeat (4) @(negedge clk);
      probeQ.push_back(mkExp({name, "_frozen"}, p, a, f, 1'b1));
      ->probeEv;
      #1;
    end
  endtask

  task automatic loadAddProgram();
    dut.rom[0] = ins(OP_LDI, 8'hF0);
    dut.rom[1] = ins(OP_STA, 8'h10);
    dut.rom[2] = ins(OP_LDI, 8'h20);
    dut.rom[3] = ins(OP_ADD, 8'h10);
    dut.rom[4] = ins(OP_HLT, 8'h00);
  endtask

  initial begin
    #1;
    holdReset("t1");
    dut.rom[0] = ins(OP_LDI, 8'h05);
    dut.rom[1] = ins(OP_HLT, 8'h00);
    applyStimulus("t1_ldi_hlt", 8'h02, 8'h05, 2'b00, 6);

    holdReset("t2");
    loadAddProgram();
    applyStimulus("t2_add_carry", 8'h05, 8'h10, 2'b10, 40);

    holdReset("t3");
    dut.rom[0] = ins(OP_LDI, 8'h03);
    dut.rom[1] = ins(OP_STA, 8'h00);
    dut.rom[2] = ins(OP_LDI, 8'h01);
    dut.rom[3] = ins(OP_STA, 8'h01);
    dut.rom[4] = ins(OP_LDA, 8'h00);
    dut.rom[5] = ins(OP_SUB, 8'h01);
    dut.rom[6] = ins(OP_STA, 8'h00);
    dut.rom[7] = ins(OP_JZ,  8'h09);
    dut.rom[8] = ins(OP_JMP, 8'h04);
    dut.rom[9] = ins(OP_HLT, 8'h00);
    applyStimulus("t3_loop", 8'h0A, 8'h00, 2'b01, 600);

    // PC increment wraps 0xFF->0x00, then JC (now taken) skips to the LDI 0x7F
    holdReset("t4");
    dut.rom[0]     = ins(OP_JC,  8'h02);
    dut.rom[1]     = ins(OP_JMP, 8'hFE);
    dut.rom[2]     = ins(OP_LDI, 8'h7F);
    dut.rom[3]     = ins(OP_HLT, 8'h00);
    dut.rom[8'hFE] = ins(OP_LDI, 8'h80);
    dut.rom[8'hFF] = ins(OP_SHL, 8'h00);
    fork
      begin
        repeat (12) @(posedge clk);
        #1;
        probeQ.push_back(mkExp("t4_wrap", 8'h00, 8'h00, 2'b11, 1'b0));
        ->probeEv;
      end
    join_none
    applyStimulus("t4_wrap_final", 8'h04, 8'h7F, 2'b10, 60);

    // Reset dropped while the ADD is in EXECUTE (acc=0x20, pc=4 at that point)
    holdReset("t5");
    loadAddProgram();
    reset = 1'b1;
    repeat (11) @(posedge clk);
    #2;
    holdReset("t5_mid_exec");
    loadAddProgram();
    applyStimulus("t5_restart", 8'h05, 8'h10, 2'b10, 40);

    holdReset("t6");
    dut.rom[0] = ins(OP_LDI, 8'h10);
    dut.rom[1] = ins(OP_STA, 8'h02);
    dut.rom[2] = ins(OP_NOT, 8'h02);
    dut.rom[3] = ins(OP_HLT, 8'h00);
`ifdef CU_MUL_EN
    applyStimulus("t6_mul", 8'h04, 8'h00, 2'b11, 40);
`else
    applyStimulus("t6_not", 8'h04, 8'hEF, 2'b00, 40);
`endif

    holdReset("t7");
    dut.rom[0]  = ins(OP_LDI, 8'h05);
    dut.rom[1]  = ins(OP_STA, 8'h04);
    dut.rom[2]  = ins(OP_LDI, 8'h03);
    dut.rom[3]  = ins(OP_SUB, 8'h04);
    dut.rom[4]  = ins(OP_XOR, 8'h04);
    dut.rom[5]  = ins(OP_AND, 8'h04);
    dut.rom[6]  = ins(OP_OR,  8'h04);
    dut.rom[7]  = ins(OP_SHR, 8'h00);
    dut.rom[8]  = ins(OP_JZ,  8'h00);
    dut.rom[9]  = ins(OP_LDA, 8'h04);
    dut.rom[10] = ins(OP_HLT, 8'h00);
    applyStimulus("t7_logic", 8'h0B, 8'h05, 2'b10, 60);

    holdReset("t8");
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
